mem_lsu: RTL and testbench

- Load/store unit in the MEM stage, directly upstream of the word-wide data memory `dm`.
- Accepts byte, halfword and word loads/stores from the pipeline, sign- or zero-extended on loads.
- Drives `dm`'s clk/addr/rd/wr/wdata/rdata interface.
- Sub-word stores are done by read-modify-write; the pipeline stalls on `busy`.

---
 rtl/mem_lsu_pkg.sv | 44 ++++
 rtl/mem_lsu_if.sv | 34 +++
 rtl/mem_lsu_align.sv | 38 +++
 rtl/mem_lsu.sv | 127 ++++++++++++
 tb/tb_mem_lsu.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: access sizes, FSM states,
// the latched request payload and the alignment rule.
package mem_lsu_pkg;

  localparam int unsigned DM_AW_DEF = 7;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned HALF_W    = 16;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_LDRET = 3'd2,
    S_MRG   = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic            we;
    size_e           size;
    logic            sign_ext;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Reserved size or a halfword/word not naturally aligned.
  function automatic logic misaligned(input size_e size, input logic [1:0] lo);
    case (size)
      SZ_HALF: return lo[0];
      SZ_WORD: return (lo != 2'b00);
      SZ_RSVD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Pipeline-side request/response and dm-side bus of the load/store unit.
interface mem_lsu_if
  import mem_lsu_pkg::*;
#(
  parameter int unsigned DM_AW = DM_AW_DEF
);

  logic             req;
  logic             we;
  logic [1:0]       size;
  logic             sign_ext;
  logic [XLEN-1:0]  addr;
  logic [XLEN-1:0]  wdata;
  logic             busy;
  logic             done;
  logic             err;
  logic [XLEN-1:0]  rdata;
  logic [DM_AW-1:0] dm_addr;
  logic             dm_rd;
  logic             dm_wr;
  logic [XLEN-1:0]  dm_wdata;
  logic [XLEN-1:0]  dm_rdata;

  modport master (
    output req, we, size, sign_ext, addr, wdata, dm_rdata,
    input  busy, done, err, rdata, dm_addr, dm_rd, dm_wr, dm_wdata
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, dm_rdata,
    output busy, done, err, rdata, dm_addr, dm_rd, dm_wr, dm_wdata
  );

endinterface

// File: rtl/mem_lsu_align.sv
// Lane logic: extracts/extends the load lane from a dm word and merges the
// store lane into it, selected by the low address bits and access size.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      lane,
  input  size_e           size,
  input  logic            sign_ext,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] ld_data_c,
  output logic [XLEN-1:0] st_word_c
);

  logic [BYTE_W-1:0] byte_c;
  logic [HALF_W-1:0] half_c;

  always_comb begin
    byte_c    = word[{lane, 3'b000} +: BYTE_W];
    half_c    = word[{lane[1], 4'b0000} +: HALF_W];
    ld_data_c = word;
    st_word_c = st_data;
    case (size)
      SZ_BYTE: begin
        ld_data_c = {{(XLEN-BYTE_W){sign_ext & byte_c[BYTE_W-1]}}, byte_c};
        st_word_c = word;
        st_word_c[{lane, 3'b000} +: BYTE_W] = st_data[BYTE_W-1:0];
      end
      SZ_HALF: begin
        ld_data_c = {{(XLEN-HALF_W){sign_ext & half_c[HALF_W-1]}}, half_c};
        st_word_c = word;
        st_word_c[{lane[1], 4'b0000} +: HALF_W] = st_data[HALF_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit in front of the word-wide dm; sub-word stores use
// read-modify-write. Define LSU_BOUNDS_CHECK_EN to flag addresses beyond dm.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned DM_AW = DM_AW_DEF
) (
  input logic     clk,
  input logic     rst_n,
  mem_lsu_if.slave bus
);

  state_e           state, state_n;
  lsu_req_t         req_q, req_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             err_q, err_n;
  logic             dm_rd_q, dm_rd_n;
  logic             dm_wr_q, dm_wr_n;
  logic [XLEN-1:0]  rdata_q, rdata_n;
  logic [XLEN-1:0]  dm_wdata_q, dm_wdata_n;
  logic [DM_AW-1:0] dm_addr_q, dm_addr_n;
  logic [XLEN-1:0]  ld_data_c;
  logic [XLEN-1:0]  st_word_c;
  logic             oob_c;

  mem_lsu_align u_align (
    .word      (bus.dm_rdata),
    .lane      (req_q.addr_lo),
    .size      (req_q.size),
    .sign_ext  (req_q.sign_ext),
    .st_data   (req_q.wdata),
    .ld_data_c (ld_data_c),
    .st_word_c (st_word_c)
  );

`ifdef LSU_BOUNDS_CHECK_EN
  assign oob_c = |bus.addr[XLEN-1:DM_AW+2];
`else
  assign oob_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      dm_rd_q    <= 1'b0;
      dm_wr_q    <= 1'b0;
      rdata_q    <= '0;
      dm_wdata_q <= '0;
      dm_addr_q  <= '0;
    end else begin
      state      <= state_n;
      req_q      <= req_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      err_q      <= err_n;
      dm_rd_q    <= dm_rd_n;
      dm_wr_q    <= dm_wr_n;
      rdata_q    <= rdata_n;
      dm_wdata_q <= dm_wdata_n;
      dm_addr_q  <= dm_addr_n;
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_n    = state;
    req_n      = req_q;
    done_n     = 1'b0;
    err_n      = 1'b0;
    rdata_n    = rdata_q;
    dm_wdata_n = dm_wdata_q;
    dm_addr_n  = dm_addr_q;
    case (state)
      S_IDLE: begin
        if (bus.req) begin
          req_n = '{we: bus.we, size: size_e'(bus.size), sign_ext: bus.sign_ext,
                    addr_lo: bus.addr[1:0], wdata: bus.wdata};
          dm_addr_n  = bus.addr[DM_AW+1:2];
          dm_wdata_n = bus.wdata;
          if (misaligned(size_e'(bus.size), bus.addr[1:0]) || oob_c) begin
            state_n = S_DONE;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else if (bus.we && size_e'(bus.size) == SZ_WORD) begin
            state_n = S_WR;
          end else begin
            state_n = S_RD;
          end
        end
      end
      S_RD:    state_n = req_q.we ? S_MRG : S_LDRET;
      S_LDRET: begin
        state_n = S_IDLE;
        rdata_n = ld_data_c;
        done_n  = 1'b1;
      end
      S_MRG: begin
        state_n    = S_WR;
        dm_wdata_n = st_word_c;
      end
      S_WR: begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    busy_n  = (state_n != S_IDLE);
    dm_rd_n = (state_n == S_RD);
    dm_wr_n = (state_n == S_WR);
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rdata    = rdata_q;
  assign bus.dm_addr  = dm_addr_q;
  assign bus.dm_rd    = dm_rd_q;
  assign bus.dm_wr    = dm_wr_q;
  assign bus.dm_wdata = dm_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: byte-array reference model feeding a per-cycle expectation
// queue, directed scenarios with literal results, then randomized traffic.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int unsigned AW     = 7;
  localparam int unsigned NWORDS = 1 << AW;
  localparam int unsigned NBYTES = NWORDS * 4;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          err;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_lsu_if #(.DM_AW(AW)) bus ();
  mem_lsu #(.DM_AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Data memory: registered read, preload port used only during reset.
  logic [31:0]   dm_mem [NWORDS];
  logic          load_en;
  logic [AW-1:0] load_idx;
  logic [31:0]   load_val;
  always @(posedge clk) begin
    if (load_en) dm_mem[load_idx] <= load_val;
    if (bus.dm_wr) dm_mem[bus.dm_addr] <= bus.dm_wdata;
    if (bus.dm_rd) bus.dm_rdata <= dm_mem[bus.dm_addr];
  end

  int          n_chk = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  logic        chk_en = 1'b0;
  logic        last_err = 1'b0;
  logic [7:0]  ref_b [NBYTES];
  logic [31:0] mdl_rdata = '0;
  logic [31:0] idle_rdata = '0;
  exp_t        q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] gather(input int unsigned bi, input int unsigned n);
    logic [31:0] v = '0;
    for (int k = 0; k < int'(n); k++) v = v | (32'(ref_b[bi + k]) << (8 * k));
    return v;
  endfunction

  // Reference: what the access does to memory/rdata and its cycle-by-cycle outputs.
  task automatic model_op(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic e);
    int unsigned wi, bi, n;
    logic [31:0] v;
    exp_t r;
    wi = (a >> 2) % NWORDS;
    bi = wi * 4 + 32'(a[1:0]);
    n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    e  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`ifdef LSU_BOUNDS_CHECK_EN
    e = e || (a[31:AW+2] != '0);
`endif
    r = '0; r.busy = 1'b1; r.rdata = mdl_rdata; r.addr = AW'(wi);
    if (e) begin
      r.done = 1'b1; r.err = 1'b1; q.push_back(r); lat = 1;
    end else if (!w) begin
      v = gather(bi, n);
      if (sx && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (sx && n == 2) v = {{16{v[15]}}, v[15:0]};
      r.rd = 1'b1; q.push_back(r);
      r.rd = 1'b0; q.push_back(r);
      r.busy = 1'b0; r.done = 1'b1; r.rdata = v; q.push_back(r);
      mdl_rdata = v; lat = 3;
    end else begin
      for (int k = 0; k < int'(n); k++) ref_b[bi + k] = 8'(d >> (8 * k));
      v = gather(wi * 4, 4);
      if (n != 4) begin
        r.rd = 1'b1; q.push_back(r);
        r.rd = 1'b0; q.push_back(r);
      end
      r.wr = 1'b1; r.wdata = v; q.push_back(r);
      r.busy = 1'b0; r.wr = 1'b0; r.done = 1'b1; q.push_back(r);
      lat = (n == 4) ? 2 : 4;
    end
  endtask

  // Per-cycle comparison of every output against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (q.size() != 0) e = q.pop_front();
      else begin e = '0; e.rdata = idle_rdata; end
      idle_rdata = e.rdata;
      if (bus.dm_wr === 1'b1) wr_cnt++;
      chk("busy", 32'(bus.busy), 32'(e.busy));
      chk("done", 32'(bus.done), 32'(e.done));
      chk("dm_rd", 32'(bus.dm_rd), 32'(e.rd));
      chk("dm_wr", 32'(bus.dm_wr), 32'(e.wr));
      chk("rdata", bus.rdata, e.rdata);
      if (e.done) chk("err", 32'(bus.err), 32'(e.err));
      if (e.rd || e.wr) chk("dm_addr", 32'(bus.dm_addr), 32'(e.addr));
      if (e.wr) chk("dm_wdata", bus.dm_wdata, e.wdata);
    end
  end

  task automatic garble();
    bus.req = 1'($urandom); bus.we = 1'($urandom); bus.size = 2'($urandom);
    bus.sign_ext = 1'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
  endtask

  // Issue at #1 after an edge with the DUT idle; returns in the done cycle.
  task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d);
    int lat;
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
    bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    model_op(w, sz, sx, a, d, lat, last_err);
    for (int c = 1; c < lat; c++) begin garble(); @(posedge clk); #1; end
    if (lat == 1) garble(); else bus.req = 1'b0;
  endtask

  task automatic settle(input int idle);
    if (last_err) begin @(posedge clk); #1; end
    bus.req = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, w;
    logic [1:0]  sz;
    rst_n = 1'b0; load_en = 1'b0; load_idx = '0; load_val = '0;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    @(posedge clk); #1;
    for (int i = 0; i < int'(NWORDS); i++) begin
      w = (i == 0) ? 32'h0BAD_BEEF : $urandom;
      for (int k = 0; k < 4; k++) ref_b[i * 4 + k] = 8'(w >> (8 * k));
      load_en = 1'b1; load_idx = AW'(i); load_val = w;
      @(posedge clk); #1;
    end
    load_en = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_dm_rd", 32'(bus.dm_rd), 32'h0);
    chk("rst_dm_wr", 32'(bus.dm_wr), 32'h0);
    rst_n = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;

    run_op(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1122_3344);
    chk("sw_done_cycle2", 32'(bus.done), 32'h1); settle(1);
    run_op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    chk("lw_rdata", bus.rdata, 32'h1122_3344);
    chk("lw_model", mdl_rdata, 32'h1122_3344);
    chk("lw_err", 32'(bus.err), 32'h0); settle(1);
    wr_cnt = 0;
    run_op(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hFFFF_FFAB); settle(1);
    chk("sb_wr_once", 32'(wr_cnt), 32'h1);
    run_op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    chk("lw_after_sb", bus.rdata, 32'h1122_AB44); settle(0);
    run_op(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0); chk("lb", bus.rdata, 32'hFFFF_FFAB);
    run_op(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0); chk("lbu", bus.rdata, 32'h0000_00AB);
    run_op(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0); chk("lh", bus.rdata, 32'h0000_1122);
    run_op(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0); chk("lhu", bus.rdata, 32'h0000_1122);
    chk("lhu_model", mdl_rdata, 32'h0000_1122); settle(1);

    wr_cnt = 0;
    run_op(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0);
    chk("lw13_err", {30'h0, bus.done, bus.err}, 32'h3); settle(1);
    run_op(1'b1, SZ_HALF, 1'b0, 32'h11, 32'h5555);
    chk("sh11_err", {30'h0, bus.done, bus.err}, 32'h3); settle(1);
    run_op(1'b1, SZ_RSVD, 1'b0, 32'h10, 32'h7777_7777);
    chk("rsvd_err", {30'h0, bus.done, bus.err}, 32'h3); settle(1);
    chk("err_no_write", 32'(wr_cnt), 32'h0);
    run_op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    chk("lw_after_err", bus.rdata, 32'h1122_AB44); settle(1);

    // Reset during the merge cycle of a byte store.
    wr_cnt = 0;
    bus.req = 1'b1; bus.we = 1'b1; bus.size = SZ_BYTE; bus.sign_ext = 1'b0;
    bus.addr = 32'h11; bus.wdata = 32'h5A;
    @(posedge clk); #1;
    begin
      exp_t r;
      r = '0; r.busy = 1'b1; r.rd = 1'b1; r.addr = AW'(4); r.rdata = mdl_rdata;
      q.push_back(r);
      r.rd = 1'b0; q.push_back(r);
      r = '0; q.push_back(r);
    end
    mdl_rdata = '0; last_err = 1'b0;
    bus.req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_busy", 32'(bus.busy), 32'h0);
    chk("rst_mid_rdata", bus.rdata, 32'h0);
    rst_n = 1'b1; settle(1);
    run_op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    chk("lw_after_abort", bus.rdata, 32'h1122_AB44); settle(1);
    chk("abort_no_write", 32'(wr_cnt), 32'h0);

    run_op(1'b1, SZ_WORD, 1'b0, 32'h200, 32'hCAFE_F00D); settle(1);
    run_op(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
`ifdef LSU_BOUNDS_CHECK_EN
    chk("bounds_word0", bus.rdata, 32'h0BAD_BEEF);
`else
    chk("wrap_word0", bus.rdata, 32'hCAFE_F00D);
`endif
    settle(1);

    for (int i = 0; i < 300; i++) begin
      a  = $urandom_range(0, NBYTES - 1);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) != 0) begin
        if (sz == 2'b11) sz = 2'b10;
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) a[31:AW+2] = (AW+2 > 0) ? 23'($urandom) : '0;
      run_op(1'($urandom), sz, 1'($urandom), a, $urandom);
      settle(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2));
    end

    repeat (3) begin @(posedge clk); #1; end
    for (int i = 0; i < int'(NWORDS); i++) chk("mem_word", dm_mem[i], gather(i * 4, 4));
    chk("queue_drained", 32'(q.size()), 32'h0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
